// File: rtl/chip8_draw_ctrl.sv
`timescale 1ns/1ps
// CHIP-8 DXYN / 00E0 sequencer: latches the command operands, fetches sprite rows over a
// req/ack memory port, strobes the framebuffer row by row and reports the collision flag into VF.
module chip8_draw_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_cmd_clear,
  input  logic [7:0]        i_vx,
  input  logic [7:0]        i_vy,
  input  logic [3:0]        i_n,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_vf_we,
  output logic [7:0]        o_vf_out,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_disp_draw,
  output logic [5:0]        o_disp_x,
  output logic [4:0]        o_disp_y,
  output logic [3:0]        o_disp_row,
  output logic [7:0]        o_disp_sprite,
  input  logic              i_disp_collision,
  output logic              o_disp_clear
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAW,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [5:0]        r_x;
  logic [4:0]        r_y;
  logic [3:0]        r_n;
  logic [3:0]        r_k;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_sprite;
  logic              r_acc;
  logic              r_is_clear;
  logic [3:0]        w_k_inc;
  logic              w_unused;

  // Screen coordinates wrap, so only the low bits of VX/VY are ever kept.
  assign w_unused = ^{i_vx[7:6], i_vy[7:5]};
  assign w_k_inc  = r_k + 4'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_vf_we      = 1'b0;
    o_mem_req    = 1'b0;
    o_disp_draw  = 1'b0;
    o_disp_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_cmd_clear) begin
          w_state_next = S_CLEAR;
        end else if (i_start) begin
          w_state_next = (i_n == 4'd0) ? S_DONE : S_FETCH;
        end
      end
      S_CLEAR: begin
        o_disp_clear = 1'b1;
        w_state_next = S_DONE;
      end
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_state_next = S_DRAW;
        end
      end
      S_DRAW: begin
        o_disp_draw  = 1'b1;
        w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_state_next = (w_k_inc == r_n) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        o_done       = 1'b1;
        o_vf_we      = ~r_is_clear;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_addr     <= '0;
      r_sprite   <= '0;
      r_acc      <= 1'b0;
      r_is_clear <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_clear) begin
            r_is_clear <= 1'b1;
            r_acc      <= 1'b0;
          end else if (i_start) begin
            r_is_clear <= 1'b0;
            r_x        <= i_vx[5:0];
            r_y        <= i_vy[4:0];
            r_n        <= i_n;
            r_addr     <= i_addr;
            r_k        <= 4'd0;
            r_acc      <= 1'b0;
          end
        end
        S_FETCH: begin
          if (i_mem_ack) begin
            r_sprite <= i_mem_rdata;
          end
        end
        // The framebuffer registers its flag on the draw edge, so it is valid here.
        S_SAMPLE: begin
          r_acc <= r_acc | i_disp_collision;
          r_k   <= w_k_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_mem_addr    = r_addr + ADDR_W'(r_k);
  assign o_vf_out      = {7'b0, r_acc};
  assign o_disp_x      = r_x;
  assign o_disp_y      = r_y;
  assign o_disp_row    = r_k;
  assign o_disp_sprite = r_sprite;

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
`timescale 1ns/1ps
// Directed bench for chip8_draw_ctrl: memory responder and 64x32 framebuffer model
// with a registered collision flag, one task per scenario.
module tb_chip8_draw_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start, i_cmd_clear;
  logic [7:0]  i_vx, i_vy;
  logic [3:0]  i_n;
  logic [11:0] i_addr;
  logic        o_busy, o_done, o_vf_we;
  logic [7:0]  o_vf_out;
  logic        o_mem_req;
  logic [11:0] o_mem_addr;
  logic        i_mem_ack;
  logic [7:0]  i_mem_rdata;
  logic        o_disp_draw;
  logic [5:0]  o_disp_x;
  logic [4:0]  o_disp_y;
  logic [3:0]  o_disp_row;
  logic [7:0]  o_disp_sprite;
  logic        i_disp_collision;
  logic        o_disp_clear;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [4096];
  logic [63:0] fb [32] = '{default: '0};

  // Results of the last run_cmd
  int          done_cycle, draws, clears, rd_n;
  logic [11:0] rd [16];
  logic [3:0]  rows [16];
  logic        vf_we_seen, early_vf, addr_unstable, busy_bad;
  logic [7:0]  vf_val;
  logic [5:0]  last_x;
  logic [4:0]  last_y;

  always #5 i_clk = ~i_clk;

  chip8_draw_ctrl #(.ADDR_W(12)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_cmd_clear(i_cmd_clear),
    .i_vx(i_vx), .i_vy(i_vy), .i_n(i_n), .i_addr(i_addr),
    .o_busy(o_busy), .o_done(o_done), .o_vf_we(o_vf_we), .o_vf_out(o_vf_out),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_disp_draw(o_disp_draw), .o_disp_x(o_disp_x),
    .o_disp_y(o_disp_y), .o_disp_row(o_disp_row), .o_disp_sprite(o_disp_sprite),
    .i_disp_collision(i_disp_collision), .o_disp_clear(o_disp_clear)
  );

  // Framebuffer model: XOR draw, collision flag registered on the draw edge
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i_disp_collision <= 1'b0;
    end else if (o_disp_clear) begin
      for (int y = 0; y < 32; y++) fb[y] <= '0;
      i_disp_collision <= 1'b0;
    end else if (o_disp_draw) begin
      automatic logic hit = 1'b0;
      for (int b = 0; b < 8; b++) begin
        automatic int px = (int'(o_disp_x) + b) % 64;
        automatic int py = (int'(o_disp_y) + int'(o_disp_row)) % 32;
        if (o_disp_sprite[7-b]) begin
          if (fb[py][px]) hit = 1'b1;
          fb[py][px] <= ~fb[py][px];
        end
      end
      i_disp_collision <= hit;
    end
  end

  function automatic int count_pixels();
    int s = 0;
    for (int y = 0; y < 32; y++) s += $countones(fb[y]);
    return s;
  endfunction

  task automatic run_cmd(input logic st, input logic cl, input logic [7:0] vx, input logic [7:0] vy,
                         input logic [3:0] n, input logic [11:0] a, input int waits, input int poke);
    logic        prev_req = 1'b0;
    logic [11:0] prev_addr = '0;
    int          wcnt = 0;
    done_cycle = -1; draws = 0; clears = 0; rd_n = 0;
    vf_we_seen = 0; early_vf = 0; addr_unstable = 0; busy_bad = 0;
    vf_val = 8'hxx; last_x = 'x; last_y = 'x;
    @(negedge i_clk);
    i_start = st; i_cmd_clear = cl; i_vx = vx; i_vy = vy; i_n = n; i_addr = a;
    @(posedge i_clk);
    #1;
    i_start = 1'b0; i_cmd_clear = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge i_clk);
      if (c == poke) begin
        i_start = 1'b1; i_cmd_clear = 1'b1; i_n = 4'd3; i_addr = 12'h100; i_vx = 8'd50;
      end else begin
        i_start = 1'b0; i_cmd_clear = 1'b0;
      end
      if (!o_busy) busy_bad = 1'b1;
      if (o_mem_req) begin
        if (prev_req && o_mem_addr !== prev_addr) addr_unstable = 1'b1;
        if (!prev_req) wcnt = 0;
        if (wcnt >= waits) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = mem[o_mem_addr];
          if (rd_n < 16) rd[rd_n] = o_mem_addr;
          rd_n++;
        end else begin
          i_mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        i_mem_ack = 1'b0;
      end
      prev_req = o_mem_req;
      prev_addr = o_mem_addr;
      if (o_disp_draw) begin
        if (draws < 16) rows[draws] = o_disp_row;
        draws++;
        last_x = o_disp_x;
        last_y = o_disp_y;
      end
      if (o_disp_clear) clears++;
      if (o_vf_we && !o_done) early_vf = 1'b1;
      if (o_done) begin
        done_cycle = c;
        vf_we_seen = o_vf_we;
        vf_val = o_vf_out;
        break;
      end
    end
    i_mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({o_busy, o_done, o_vf_we, o_mem_req, o_disp_draw, o_disp_clear} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {o_busy, o_done, o_vf_we, o_mem_req, o_disp_draw, o_disp_clear});
    end
    tests++;
    if ({o_vf_out, o_mem_addr, o_disp_x, o_disp_y, o_disp_row, o_disp_sprite} !== 43'b0) begin
      fails++;
      $display("FAIL reset_data: vf=%h addr=%h x=%0d y=%0d row=%0d spr=%h expected all 0",
               o_vf_out, o_mem_addr, o_disp_x, o_disp_y, o_disp_row, o_disp_sprite);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_simple_draw();
    run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd5, 12'h050, 0, 0);
    tests++;
    if (done_cycle != 16) begin
      fails++; $display("FAIL draw_done_cycle: got %0d expected 16", done_cycle);
    end
    tests++;
    if (vf_we_seen !== 1'b1 || vf_val !== 8'h00 || early_vf) begin
      fails++; $display("FAIL draw_vf: vf_we=%b vf=%h early=%b expected 1/00/0", vf_we_seen, vf_val, early_vf);
    end
    tests++;
    if (rd_n != 5 || draws != 5) begin
      fails++; $display("FAIL draw_counts: reads=%0d draws=%0d expected 5/5", rd_n, draws);
    end
    for (int k = 0; k < 5 && k < rd_n && k < draws; k++) begin
      tests++;
      if (rd[k] !== 12'h050 + 12'(k) || rows[k] !== 4'(k)) begin
        fails++; $display("FAIL draw_row%0d: addr=%h row=%0d expected %h/%0d", k, rd[k], rows[k], 12'h050 + 12'(k), k);
      end
    end
    tests++;
    if (busy_bad) begin
      fails++; $display("FAIL draw_busy: busy low during command, expected high");
    end
    tests++;
    if (count_pixels() != 14) begin
      fails++; $display("FAIL draw_pixels: got %0d expected 14", count_pixels());
    end
  endtask

  task automatic test_redraw_collision();
    run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd5, 12'h050, 0, 0);
    tests++;
    if (done_cycle != 16 || vf_we_seen !== 1'b1 || vf_val !== 8'h01) begin
      fails++; $display("FAIL redraw_vf: cycle=%0d vf_we=%b vf=%h expected 16/1/01", done_cycle, vf_we_seen, vf_val);
    end
    tests++;
    if (count_pixels() != 0) begin
      fails++; $display("FAIL redraw_pixels: got %0d expected 0", count_pixels());
    end
  endtask

  task automatic test_wrap();
    run_cmd(1'b1, 1'b0, 8'd70, 8'd40, 4'd3, 12'hFFE, 0, 0);
    tests++;
    if (last_x !== 6'd6 || last_y !== 5'd8) begin
      fails++; $display("FAIL wrap_xy: x=%0d y=%0d expected 6/8", last_x, last_y);
    end
    tests++;
    if (rd_n != 3 || rd[0] !== 12'hFFE || rd[1] !== 12'hFFF || rd[2] !== 12'h000) begin
      fails++; $display("FAIL wrap_addr: n=%0d %h %h %h expected 3 FFE FFF 000", rd_n, rd[0], rd[1], rd[2]);
    end
    tests++;
    if (done_cycle != 10 || vf_val !== 8'h00) begin
      fails++; $display("FAIL wrap_done: cycle=%0d vf=%h expected 10/00", done_cycle, vf_val);
    end
  endtask

  task automatic test_wait_states();
    run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd2, 12'h050, 2, 0);
    tests++;
    if (done_cycle != 11) begin
      fails++; $display("FAIL wait_done_cycle: got %0d expected 11", done_cycle);
    end
    tests++;
    if (addr_unstable) begin
      fails++; $display("FAIL wait_addr_stable: mem_addr changed while mem_req, expected stable");
    end
    tests++;
    if (rd_n != 2 || rd[0] !== 12'h050 || rd[1] !== 12'h051 || vf_val !== 8'h00) begin
      fails++; $display("FAIL wait_reads: n=%0d %h %h vf=%h expected 2 050 051 00", rd_n, rd[0], rd[1], vf_val);
    end
  endtask

  task automatic test_conflict();
    run_cmd(1'b1, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 0, 0);
    tests++;
    if (clears != 1 || rd_n != 0 || draws != 0 || done_cycle != 2 || vf_we_seen !== 1'b0) begin
      fails++; $display("FAIL conflict_clear: clears=%0d reads=%0d draws=%0d cycle=%0d vf_we=%b expected 1/0/0/2/0",
                        clears, rd_n, draws, done_cycle, vf_we_seen);
    end
    tests++;
    if (count_pixels() != 0) begin
      fails++; $display("FAIL conflict_pixels: got %0d expected 0", count_pixels());
    end
  endtask

  task automatic test_busy_ignore();
    run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h050, 0, 2);
    tests++;
    if (done_cycle != 4 || clears != 0 || rd_n != 1 || rd[0] !== 12'h050 || last_x !== 6'd0) begin
      fails++; $display("FAIL ignore_cmd: cycle=%0d clears=%0d reads=%0d addr=%h x=%0d expected 4/0/1/050/0",
                        done_cycle, clears, rd_n, rd[0], last_x);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      tests++;
      if (o_busy !== 1'b0 || o_mem_req !== 1'b0 || o_disp_clear !== 1'b0) begin
        fails++; $display("FAIL ignore_not_queued: busy=%b req=%b clr=%b expected 000", o_busy, o_mem_req, o_disp_clear);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1; i_vx = 8'd20; i_vy = 8'd10; i_n = 4'd8; i_addr = 12'h050;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_mem_req && o_mem_addr == 12'h052) begin
        found = 1'b1;
        break;
      end
      i_mem_ack = o_mem_req;
      i_mem_rdata = mem[o_mem_addr];
    end
    i_mem_ack = 1'b0;
    i_rst_n = 1'b0;
    #1;
    tests++;
    if (!found || {o_busy, o_mem_req, o_done, o_vf_we, o_disp_draw} !== 5'b0 ||
        o_mem_addr !== 12'h000 || o_disp_row !== 4'd0 || o_disp_sprite !== 8'h00) begin
      fails++; $display("FAIL reset_mid_immediate: found=%b busy=%b req=%b addr=%h row=%0d spr=%h expected 1/0/0/000/0/00",
                        found, o_busy, o_mem_req, o_mem_addr, o_disp_row, o_disp_sprite);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      tests++;
      if (o_done !== 1'b0 || o_vf_we !== 1'b0) begin
        fails++; $display("FAIL reset_mid_no_done: done=%b vf_we=%b expected 0/0", o_done, o_vf_we);
      end
    end
    i_rst_n = 1'b1;
    run_cmd(1'b1, 1'b0, 8'd40, 8'd20, 4'd2, 12'h050, 0, 0);
    tests++;
    if (done_cycle != 7 || vf_we_seen !== 1'b1 || vf_val !== 8'h00 || rd_n != 2 || last_x !== 6'd40) begin
      fails++; $display("FAIL reset_mid_after: cycle=%0d vf_we=%b vf=%h reads=%0d x=%0d expected 7/1/00/2/40",
                        done_cycle, vf_we_seen, vf_val, rd_n, last_x);
    end
  endtask

  task automatic test_zero_rows();
    run_cmd(1'b1, 1'b0, 8'd3, 8'd3, 4'd0, 12'h050, 0, 0);
    tests++;
    if (done_cycle != 1 || vf_we_seen !== 1'b1 || vf_val !== 8'h00 || rd_n != 0 || draws != 0) begin
      fails++; $display("FAIL zero_rows: cycle=%0d vf_we=%b vf=%h reads=%0d draws=%0d expected 1/1/00/0/0",
                        done_cycle, vf_we_seen, vf_val, rd_n, draws);
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_cmd_clear = 1'b0;
    i_vx = '0; i_vy = '0; i_n = '0; i_addr = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
    mem[12'hFFE] = 8'h81; mem[12'hFFF] = 8'h42; mem[12'h000] = 8'h24;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_simple_draw();
    test_redraw_collision();
    test_wrap();
    test_wait_states();
    test_conflict();
    test_busy_ignore();
    test_zero_rows();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
